// File: rtl/pkt_stream_checker_if.sv
// Bundles the packet stream handshake and the CPU register port of the stream checker.
`timescale 1ns/1ps
interface pkt_stream_checker_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic                  in_wr;
  logic                  in_rdy;
  logic [63:0]           cpu_addr_in;
  logic [63:0]           cpu_din;
  logic                  cpu_wen;
  logic [63:0]           cpu_dout;

  modport master (
    output in_data, in_ctrl, in_wr, cpu_addr_in, cpu_din, cpu_wen,
    input  in_rdy, cpu_dout
  );

  modport slave (
    input  in_data, in_ctrl, in_wr, cpu_addr_in, cpu_din, cpu_wen,
    output in_rdy, cpu_dout
  );
endinterface

// File: rtl/pkt_stream_checker.sv
// Stream sink that applies programmable backpressure, checks framing and the
// {packet, index} payload pattern, and exposes counters over the register port.
`timescale 1ns/1ps
module pkt_stream_checker #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input logic clk,
  input logic rst,
  pkt_stream_checker_if.slave bus
);
  localparam int IDX_W = $clog2(MAX_WORDS) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_PAY  = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  logic [1:0]            state, state_nxt;
  logic [IDX_W-1:0]      widx, widx_nxt, widx_inc;
  logic                  pkt_bad, pkt_bad_nxt;
  logic [31:0]           pkt_cnt, bad_pkt_cnt, word_cnt, err_cnt, ovf_cnt;
  logic [63:0]           last_err;
  logic                  framing_f, length_f, data_f, ovf_f;
  logic [7:0]            throttle, cyc_cnt, cyc_nxt;
  logic                  rdy_q;
  logic [63:0]           dout_q, rd_data;

  logic                  accept, ovf_evt, clear, load_thr;
  logic                  is_hdr, is_pay, is_last;
  logic                  framing, length, check, done, drop_done;
  logic                  data_err, err_evt, good_done, bad_done;
  logic [CTRL_WIDTH-1:0] byte_mask;
  logic [DATA_WIDTH-1:0] lane_mask, exp_word;
  logic                  unused_bits;

  assign bus.in_rdy   = rdy_q;
  assign bus.cpu_dout = dout_q;
  assign unused_bits  = ^{bus.cpu_addr_in[63:3], bus.cpu_din[63:16], bus.cpu_din[7:2]};

  assign accept   = bus.in_wr && rdy_q;
  assign ovf_evt  = bus.in_wr && !rdy_q;
  assign clear    = bus.cpu_wen && (bus.cpu_addr_in[2:0] == 3'd7) && bus.cpu_din[0];
  assign load_thr = bus.cpu_wen && (bus.cpu_addr_in[2:0] == 3'd7) && bus.cpu_din[1];
  assign is_hdr   = (bus.in_ctrl == '1);
  assign is_pay   = (bus.in_ctrl == '0);
  assign is_last  = $onehot(bus.in_ctrl);
  assign widx_inc = widx + IDX_W'(1);
  assign exp_word = {pkt_cnt, 32'(widx)};

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // A one-hot ctrl bit k marks byte lanes k..7 valid, so ~(ctrl-1) is the lane mask.
  always_comb begin
    byte_mask = is_last ? ~(bus.in_ctrl - CTRL_WIDTH'(1)) : '1;
    lane_mask = '0;
    for (int j = 0; j < CTRL_WIDTH; j++) begin
      lane_mask[8*j +: 8] = {8{byte_mask[j]}};
    end
  end

  always_comb begin
    state_nxt   = state;
    widx_nxt    = widx;
    pkt_bad_nxt = pkt_bad;
    framing     = 1'b0;
    length      = 1'b0;
    check       = 1'b0;
    done        = 1'b0;
    drop_done   = 1'b0;
    if (accept) begin
      case (state)
        ST_IDLE: begin
          if (is_hdr) begin
            state_nxt   = ST_HDR;
            widx_nxt    = '0;
            pkt_bad_nxt = 1'b0;
          end else if (is_last) begin
            framing = 1'b1;
          end else begin
            framing   = 1'b1;
            state_nxt = ST_DROP;
          end
        end
        ST_HDR: begin
          if (is_hdr) begin
            state_nxt = ST_HDR;
          end else if (is_pay) begin
            check     = 1'b1;
            widx_nxt  = IDX_W'(1);
            state_nxt = ST_PAY;
          end else if (is_last) begin
            check     = 1'b1;
            done      = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            framing   = 1'b1;
            state_nxt = ST_DROP;
          end
        end
        ST_PAY: begin
          if (is_pay) begin
            check    = 1'b1;
            widx_nxt = widx_inc;
            if (widx_inc == IDX_W'(MAX_WORDS)) begin
              length    = 1'b1;
              state_nxt = ST_DROP;
            end
          end else if (is_last) begin
            check     = 1'b1;
            done      = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            framing   = 1'b1;
            state_nxt = ST_DROP;
          end
        end
        default: begin
          if (is_last) begin
            drop_done = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      endcase
    end
  end

  // Framing and length errors take precedence, so at most one event per word.
  assign data_err  = check && !length && (((bus.in_data ^ exp_word) & lane_mask) != '0);
  assign err_evt   = framing || length || data_err;
  assign good_done = done && !pkt_bad && !data_err;
  assign bad_done  = (done && (pkt_bad || data_err)) || drop_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      widx        <= '0;
      pkt_bad     <= 1'b0;
      pkt_cnt     <= '0;
      bad_pkt_cnt <= '0;
      word_cnt    <= '0;
      err_cnt     <= '0;
      ovf_cnt     <= '0;
      last_err    <= '0;
      framing_f   <= 1'b0;
      length_f    <= 1'b0;
      data_f      <= 1'b0;
      ovf_f       <= 1'b0;
    end else if (clear) begin
      state       <= ST_IDLE;
      widx        <= '0;
      pkt_bad     <= 1'b0;
      pkt_cnt     <= '0;
      bad_pkt_cnt <= '0;
      word_cnt    <= '0;
      err_cnt     <= '0;
      ovf_cnt     <= '0;
      last_err    <= '0;
      framing_f   <= 1'b0;
      length_f    <= 1'b0;
      data_f      <= 1'b0;
      ovf_f       <= 1'b0;
    end else begin
      if (ovf_evt) begin
        ovf_cnt <= sat_inc(ovf_cnt);
        ovf_f   <= 1'b1;
      end
      if (accept) begin
        state    <= state_nxt;
        widx     <= widx_nxt;
        pkt_bad  <= pkt_bad_nxt || data_err;
        word_cnt <= sat_inc(word_cnt);
        if (err_evt)   err_cnt     <= sat_inc(err_cnt);
        if (framing)   framing_f   <= 1'b1;
        if (length)    length_f    <= 1'b1;
        if (good_done) pkt_cnt     <= sat_inc(pkt_cnt);
        if (bad_done)  bad_pkt_cnt <= sat_inc(bad_pkt_cnt);
        if (data_err) begin
          data_f <= 1'b1;
          if (!data_f) last_err <= bus.in_data;
        end
      end
    end
  end

  // Cycle counter runs 1..throttle; ready drops for the one cycle it sits at throttle.
  always_comb begin
    if (throttle == 8'd0) begin
      cyc_nxt = 8'd0;
    end else if (cyc_cnt >= throttle) begin
      cyc_nxt = 8'd1;
    end else begin
      cyc_nxt = cyc_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      throttle <= 8'd0;
      cyc_cnt  <= 8'd0;
      rdy_q    <= 1'b0;
    end else begin
      if (load_thr) throttle <= bus.cpu_din[15:8];
      cyc_cnt <= cyc_nxt;
      rdy_q   <= !((throttle != 8'd0) && (cyc_nxt == throttle));
    end
  end

  always_comb begin
    rd_data = '0;
    case (bus.cpu_addr_in[2:0])
      3'd0:    rd_data = {32'd0, pkt_cnt};
      3'd1:    rd_data = {32'd0, bad_pkt_cnt};
      3'd2:    rd_data = {32'd0, word_cnt};
      3'd3:    rd_data = {32'd0, err_cnt};
      3'd4:    rd_data = {32'd0, ovf_cnt};
      3'd5:    rd_data = last_err;
      3'd6:    rd_data = {48'd0, throttle, ovf_f, data_f, length_f, framing_f, 2'b00, state};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= rd_data;
    end
  end
endmodule

// File: tb/tb_pkt_stream_checker.sv
// Directed self-checking bench for pkt_stream_checker: framing, payload, throttle and clear.
`timescale 1ns/1ps
module tb_pkt_stream_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pkt_stream_checker_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) bus ();

  pkt_stream_checker #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .MAX_WORDS(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for ready, then presents one word for exactly one clock.
  task automatic applyStimulus(input logic [7:0] ctrl, input logic [63:0] data);
    int waited;
    waited = 0;
    while (!bus.in_rdy && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_rdy) checkOutput("rdy_timeout", {63'd0, bus.in_rdy}, 64'd1);
    bus.in_ctrl = ctrl;
    bus.in_data = data;
    bus.in_wr   = 1'b1;
    @(negedge clk);
    bus.in_wr   = 1'b0;
  endtask

  task automatic readReg(input logic [2:0] addr, output logic [63:0] value);
    bus.cpu_addr_in = {61'd0, addr};
    bus.cpu_wen     = 1'b0;
    @(negedge clk);
    value = bus.cpu_dout;
  endtask

  task automatic checkReg(input string tag, input logic [2:0] addr, input logic [63:0] expected);
    logic [63:0] value;
    readReg(addr, value);
    checkOutput(tag, value, expected);
  endtask

  task automatic writeCtrl(input logic [63:0] data);
    bus.cpu_addr_in = 64'd7;
    bus.cpu_din     = data;
    bus.cpu_wen     = 1'b1;
    @(negedge clk);
    bus.cpu_wen     = 1'b0;
    bus.cpu_din     = 64'd0;
  endtask

  // Two headers then npay payload words {pkt, idx}; word bad_idx is replaced by bad_data.
  task automatic sendPacket(input int pkt, input int npay, input logic [7:0] last_ctrl,
                            input int bad_idx, input logic [63:0] bad_data);
    logic [63:0] d;
    logic [7:0]  c;
    applyStimulus(8'hFF, 64'h0);
    applyStimulus(8'hFF, 64'h1);
    for (int i = 0; i < npay; i++) begin
      d = (i == bad_idx) ? bad_data : {32'(pkt), 32'(i)};
      c = (i == npay - 1) ? last_ctrl : 8'h00;
      applyStimulus(c, d);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lows;
    bus.in_data     = 64'd0;
    bus.in_ctrl     = 8'd0;
    bus.in_wr       = 1'b0;
    bus.cpu_addr_in = 64'd0;
    bus.cpu_din     = 64'd0;
    bus.cpu_wen     = 1'b0;
    rst             = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rdy_in_reset", {63'd0, bus.in_rdy}, 64'd0);
    checkOutput("dout_in_reset", bus.cpu_dout, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rdy_after_reset", {63'd0, bus.in_rdy}, 64'd1);
    checkReg("pkt_reset", 3'd0, 64'd0);
    checkReg("status_reset", 3'd6, 64'd0);

    $display("[TB] clean traffic");
    for (int p = 0; p < 3; p++) sendPacket(p, 4, 8'h01, -1, 64'd0);
    checkReg("clean_pkt", 3'd0, 64'd3);
    checkReg("clean_word", 3'd2, 64'd18);
    checkReg("clean_err", 3'd3, 64'd0);
    checkReg("clean_status", 3'd6, 64'd0);

    $display("[TB] bad payload");
    writeCtrl(64'h1);
    sendPacket(0, 4, 8'h01, -1, 64'd0);
    sendPacket(1, 4, 8'h01, 2, 64'hDEAD);
    sendPacket(1, 4, 8'h01, -1, 64'd0);
    checkReg("bad_badpkt", 3'd1, 64'd1);
    checkReg("bad_err", 3'd3, 64'd1);
    checkReg("bad_lasterr", 3'd5, 64'hDEAD);
    checkReg("bad_status", 3'd6, 64'h40);
    checkReg("bad_pkt", 3'd0, 64'd2);

    $display("[TB] masked last word");
    writeCtrl(64'h1);
    sendPacket(0, 2, 8'h80, 1, 64'h00AB_CDEF_1234_5678);
    checkReg("mask_err", 3'd3, 64'd0);
    checkReg("mask_pkt", 3'd0, 64'd1);
    sendPacket(1, 2, 8'h01, 1, 64'h00AB_CDEF_1234_5678);
    checkReg("full_err", 3'd3, 64'd1);
    checkReg("full_badpkt", 3'd1, 64'd1);
    checkReg("full_pkt", 3'd0, 64'd1);

    $display("[TB] framing faults");
    writeCtrl(64'h1);
    applyStimulus(8'h00, 64'd0);
    checkReg("idle_pay_status", 3'd6, 64'h13);
    applyStimulus(8'h00, 64'd5);
    applyStimulus(8'hFF, 64'd0);
    applyStimulus(8'h01, 64'd0);
    checkReg("idle_pay_err", 3'd3, 64'd1);
    checkReg("idle_pay_badpkt", 3'd1, 64'd1);
    sendPacket(0, 4, 8'h01, -1, 64'd0);
    checkReg("idle_pay_next_pkt", 3'd0, 64'd1);
    applyStimulus(8'hFF, 64'd0);
    applyStimulus(8'h00, {32'd1, 32'd0});
    applyStimulus(8'hFF, 64'd0);
    checkReg("hdr_in_pay_err", 3'd3, 64'd2);
    checkReg("hdr_in_pay_status", 3'd6, 64'h13);
    applyStimulus(8'h01, 64'd0);
    sendPacket(1, 4, 8'h01, -1, 64'd0);
    checkReg("hdr_in_pay_pkt", 3'd0, 64'd2);
    checkReg("hdr_in_pay_badpkt", 3'd1, 64'd2);

    $display("[TB] throttle and overflow");
    writeCtrl(64'h1);
    writeCtrl(64'h0302);
    checkReg("thr_status", 3'd6, 64'h0300);
    lows = 0;
    repeat (6) begin
      @(negedge clk);
      if (!bus.in_rdy) lows++;
    end
    checkOutput("thr_rdy_lows", 64'(lows), 64'd2);
    bus.in_ctrl = 8'h01;
    bus.in_data = 64'd0;
    bus.in_wr   = 1'b1;
    repeat (30) @(negedge clk);
    bus.in_wr   = 1'b0;
    checkReg("ovf_cnt", 3'd4, 64'd10);
    checkReg("ovf_status", 3'd6, 64'h0390);
    checkReg("ovf_word", 3'd2, 64'd20);
    checkReg("ovf_err", 3'd3, 64'd20);
    writeCtrl(64'h0002);

    $display("[TB] length error and clear");
    writeCtrl(64'h1);
    sendPacket(0, 257, 8'h01, -1, 64'd0);
    checkReg("len_err", 3'd3, 64'd1);
    checkReg("len_badpkt", 3'd1, 64'd1);
    checkReg("len_pkt", 3'd0, 64'd0);
    checkReg("len_status", 3'd6, 64'h20);
    checkReg("len_word", 3'd2, 64'd259);
    applyStimulus(8'hFF, 64'd0);
    bus.in_ctrl     = 8'h00;
    bus.in_data     = 64'd0;
    bus.in_wr       = 1'b1;
    bus.cpu_addr_in = 64'd7;
    bus.cpu_din     = 64'h1;
    bus.cpu_wen     = 1'b1;
    @(negedge clk);
    bus.in_wr       = 1'b0;
    bus.cpu_wen     = 1'b0;
    bus.cpu_din     = 64'd0;
    checkReg("clr_word", 3'd2, 64'd0);
    checkReg("clr_status", 3'd6, 64'd0);
    checkReg("clr_err", 3'd3, 64'd0);
    checkReg("clr_badpkt", 3'd1, 64'd0);

    $display("[TB] reset mid-packet");
    applyStimulus(8'hFF, 64'd0);
    applyStimulus(8'h00, 64'd0);
    checkReg("mid_status", 3'd6, 64'h2);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_rdy", {63'd0, bus.in_rdy}, 64'd0);
    checkOutput("mid_rst_dout", bus.cpu_dout, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rdy_after", {63'd0, bus.in_rdy}, 64'd1);
    sendPacket(0, 4, 8'h01, -1, 64'd0);
    checkReg("mid_next_pkt", 3'd0, 64'd1);
    checkReg("mid_next_err", 3'd3, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
